// File: rtl/csa_pkg.sv
// Shared constants and operand type for the 4-bit carry-select adder.
package csa_pkg;

    localparam int CSA_WIDTH   = 4;
    localparam int CSA_GROUP_W = 2;

    typedef logic [CSA_WIDTH-1:0] csa_operand_t;

endpackage : csa_pkg

// File: rtl/csa_ripple_block.sv
// 2-bit ripple-carry adder built from full-adder equations; one instance per group/path.
import csa_pkg::*;

module csa_ripple_block (
    input  logic [CSA_GROUP_W-1:0] a,
    input  logic [CSA_GROUP_W-1:0] b,
    input  logic                   ci,
    output logic [CSA_GROUP_W-1:0] s,
    output logic                   co
);

    logic w_c1;

    assign s[0] = a[0] ^ b[0] ^ ci;
    assign w_c1 = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
    assign s[1] = a[1] ^ b[1] ^ w_c1;
    assign co   = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));

endmodule : csa_ripple_block

// File: rtl/carry_select_adder_4bits.sv
// 4-bit carry-select adder: low group ripples, high group is precomputed for both
// carry-in values and picked by the low-group carry; result registered once.
import csa_pkg::*;

module carry_select_adder_4bits (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  csa_operand_t             A,
    input  csa_operand_t             B,
    input  logic                     Cin,
    output csa_operand_t             S,
    output logic                     Cout,
    output logic                     out_valid
);

    logic [CSA_GROUP_W-1:0] w_s_lo;
    logic [CSA_GROUP_W-1:0] w_s_h0;
    logic [CSA_GROUP_W-1:0] w_s_h1;
    logic                   w_c_lo;
    logic                   w_c_h0;
    logic                   w_c_h1;
    logic [CSA_GROUP_W:0]   w_sum_hi;
    csa_operand_t           w_s_c;
    logic                   w_cout_c;

    csa_operand_t           r_s;
    logic                   r_cout;
    logic                   r_out_valid;

    csa_ripple_block u_lo (
        .a  (A[CSA_GROUP_W-1:0]),
        .b  (B[CSA_GROUP_W-1:0]),
        .ci (Cin),
        .s  (w_s_lo),
        .co (w_c_lo)
    );

    csa_ripple_block u_hi0 (
        .a  (A[CSA_WIDTH-1:CSA_GROUP_W]),
        .b  (B[CSA_WIDTH-1:CSA_GROUP_W]),
        .ci (1'b0),
        .s  (w_s_h0),
        .co (w_c_h0)
    );

    csa_ripple_block u_hi1 (
        .a  (A[CSA_WIDTH-1:CSA_GROUP_W]),
        .b  (B[CSA_WIDTH-1:CSA_GROUP_W]),
        .ci (1'b1),
        .s  (w_s_h1),
        .co (w_c_h1)
    );

    // Low-group carry picks the precomputed high-group result.
    always_comb begin
        w_sum_hi = {w_c_h0, w_s_h0};
        if (w_c_lo) begin
            w_sum_hi = {w_c_h1, w_s_h1};
        end else begin
            w_sum_hi = {w_c_h0, w_s_h0};
        end
    end

    assign {w_cout_c, w_s_c} = {w_sum_hi, w_s_lo};

    // Output stage: capture on valid, otherwise hold the sum and drop the valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= 4'b0000;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            r_s         <= w_s_c;
            r_cout      <= w_cout_c;
            r_out_valid <= 1'b1;
        end else begin
            r_s         <= r_s;
            r_cout      <= r_cout;
            r_out_valid <= 1'b0;
        end
    end

    assign S         = r_s;
    assign Cout      = r_cout;
    assign out_valid = r_out_valid;

endmodule : carry_select_adder_4bits

// File: tb/tb_carry_select_adder_4bits.sv
// Scoreboard bench for carry_select_adder_4bits: expected {out_valid,Cout,S} queued at drive time.
module tb_carry_select_adder_4bits;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] A        = 4'd0;
    logic [3:0] B        = 4'd0;
    logic       Cin      = 1'b0;
    logic [3:0] S;
    logic       Cout;
    logic       out_valid;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] sb_q[$];
    logic [4:0] model_hold = 5'd0;

    carry_select_adder_4bits dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .Cout      (Cout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got {vld,cout,s}=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input string tag, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic c);
        logic [5:0] exp;
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = c;
        if (v) model_hold = {1'b0, a} + {1'b0, b} + {4'd0, c};
        sb_q.push_back({v, model_hold});
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check_eq(tag, {out_valid, Cout, S}, exp);
    endtask

    initial begin
        #12;
        check_eq("reset_state", {out_valid, Cout, S}, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;

        drive("5+6",      1'b1, 4'd5,  4'd6,  1'b0);
        drive("15+1",     1'b1, 4'd15, 4'd1,  1'b0);
        drive("15+15+1",  1'b1, 4'd15, 4'd15, 1'b1);
        drive("0+0+1",    1'b1, 4'd0,  4'd0,  1'b1);
        drive("3+1",      1'b1, 4'd3,  4'd1,  1'b0);
        drive("hold",     1'b0, 4'd9,  4'd1,  1'b0);
        drive("hold2",    1'b0, 4'd7,  4'd7,  1'b1);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v9;
            v9 = 9'(i);
            drive("sweep", 1'b1, v9[8:5], v9[4:1], v9[0]);
        end

        // Asynchronous reset between edges while a valid input is pending.
        drive("pre_rst", 1'b1, 4'd7, 4'd8, 1'b0);
        in_valid = 1'b1;
        A        = 4'd12;
        B        = 4'd9;
        Cin      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", {out_valid, Cout, S}, 6'b000000);
        model_hold = 5'd0;
        @(posedge clk);
        #1;
        check_eq("rst_wins", {out_valid, Cout, S}, 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst_9+8", 1'b1, 4'd9, 4'd8, 1'b1);
        drive("post_rst_idle", 1'b0, 4'd1, 4'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_carry_select_adder_4bits
